// File: rtl/multicore_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between N picorv32 native-bus cores.
// Each core's local window is relocated to base i*REGION_BYTES; one transaction in flight.
module multicore_mem_arbiter #(
  parameter int unsigned N            = 2,
  parameter int unsigned REGION_BYTES = 1024,
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF,
  localparam int unsigned GW          = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          core_valid,
  input  logic [N-1:0]          core_instr,
  input  logic [N-1:0][31:0]    core_addr,
  input  logic [N-1:0][31:0]    core_wdata,
  input  logic [N-1:0][3:0]     core_wstrb,
  output logic [N-1:0]          core_ready,
  output logic [N-1:0][31:0]    core_rdata,
  output logic [N-1:0]          core_err,
  output logic                  mem_valid,
  output logic                  mem_instr,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata,
  output logic [GW-1:0]         grant_id
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e        state_q;
  logic [GW-1:0] last_q;
  logic [15:0]   cnt_q;

  logic [GW-1:0] sel;
  logic [GW-1:0] cand;
  logic          any_valid;
  logic          in_range;
  logic [31:0]   reloc_addr;

  // Scan starts just above the last grant so the served core ranks last.
  always_comb begin
    sel       = last_q;
    cand      = last_q;
    any_valid = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = GW'((32'(last_q) + k) % N);
      if (!any_valid && core_valid[cand]) begin
        any_valid = 1'b1;
        sel       = cand;
      end
    end
    in_range   = core_addr[sel] < 32'(REGION_BYTES);
    reloc_addr = 32'(sel) * 32'(REGION_BYTES) + core_addr[sel];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      last_q     <= GW'(N - 1);
      cnt_q      <= '0;
      core_ready <= '0;
      core_rdata <= '0;
      core_err   <= '0;
      mem_valid  <= 1'b0;
      mem_instr  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      grant_id   <= '0;
    end else begin
      core_ready <= '0;
      core_err   <= '0;
      unique case (state_q)
        StIdle: begin
          if (any_valid) begin
            grant_id <= sel;
            if (in_range) begin
              mem_valid <= 1'b1;
              mem_addr  <= reloc_addr;
              mem_instr <= core_instr[sel];
              mem_wdata <= core_wdata[sel];
              mem_wstrb <= core_wstrb[sel];
              state_q   <= StIssue;
            end else begin
              // Out-of-window access completes with an error and never reaches memory.
              core_ready[sel] <= 1'b1;
              core_err[sel]   <= 1'b1;
              core_rdata[sel] <= ERR_DATA;
              state_q         <= StResp;
            end
          end
        end
        StIssue: begin
          if (mem_ready) begin
            mem_valid            <= 1'b0;
            core_ready[grant_id] <= 1'b1;
            core_rdata[grant_id] <= mem_rdata;
            state_q              <= StResp;
          end else if (cnt_q == 16'(TIMEOUT - 1)) begin
            mem_valid            <= 1'b0;
            core_ready[grant_id] <= 1'b1;
            core_err[grant_id]   <= 1'b1;
            core_rdata[grant_id] <= ERR_DATA;
            state_q              <= StResp;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StResp: begin
          last_q  <= grant_id;
          cnt_q   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_multicore_mem_arbiter.sv
// Scoreboard bench: drivers push expected completions, a monitor pops them on core_ready,
// and a behavioural memory responder checks every downstream request against its queue.
module tb_multicore_mem_arbiter;

  localparam int unsigned N      = 2;
  localparam int unsigned REGION = 1024;
  localparam int unsigned TMO    = 4;
  localparam logic [31:0] ERRD   = 32'hDEADBEEF;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        core_valid;
  logic [N-1:0]        core_instr;
  logic [N-1:0][31:0]  core_addr;
  logic [N-1:0][31:0]  core_wdata;
  logic [N-1:0][3:0]   core_wstrb;
  logic [N-1:0]        core_ready;
  logic [N-1:0][31:0]  core_rdata;
  logic [N-1:0]        core_err;
  logic                mem_valid;
  logic                mem_instr;
  logic [31:0]         mem_addr;
  logic [31:0]         mem_wdata;
  logic [3:0]          mem_wstrb;
  logic                mem_ready;
  logic [31:0]         mem_rdata;
  logic [0:0]          grant_id;

  multicore_mem_arbiter #(
    .N            (N),
    .REGION_BYTES (REGION),
    .TIMEOUT      (TMO),
    .ERR_DATA     (ERRD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .core_valid (core_valid),
    .core_instr (core_instr),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_wstrb (core_wstrb),
    .core_ready (core_ready),
    .core_rdata (core_rdata),
    .core_err   (core_err),
    .mem_valid  (mem_valid),
    .mem_instr  (mem_instr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    int          lat;
  } req_t;

  typedef struct {
    logic        err;
    logic        chk_data;
    logic [31:0] rdata;
  } exp_t;

  req_t        req_q [N][$];
  exp_t        exp_q [N][$];
  logic [31:0] mem    [int unsigned];
  logic [31:0] shadow [int unsigned];
  int          served_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  function automatic logic [31:0] init_word(input int unsigned w);
    return (w * 32'h01000193) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] ws);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (ws[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Issue one core transaction; expected completion follows from window/timeout rules.
  task automatic do_txn(input int i, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic ins, input int lat, input int gap);
    exp_t        e;
    req_t        r;
    int unsigned key;
    int          n;
    key = (32'(i) * REGION + a) >> 2;
    if (a >= REGION) begin
      e = '{err: 1'b1, chk_data: 1'b1, rdata: ERRD};
    end else begin
      r = '{addr: a, wdata: wd, wstrb: ws, instr: ins, lat: lat};
      req_q[i].push_back(r);
      if (lat >= int'(TMO)) begin
        e = '{err: 1'b1, chk_data: 1'b1, rdata: ERRD};
      end else if (ws == 4'd0) begin
        e = '{err: 1'b0, chk_data: 1'b1,
              rdata: shadow.exists(key) ? shadow[key] : init_word(key)};
      end else begin
        e = '{err: 1'b0, chk_data: 1'b0, rdata: 32'd0};
        shadow[key] = merge(shadow.exists(key) ? shadow[key] : init_word(key), wd, ws);
      end
    end
    exp_q[i].push_back(e);
    core_addr[i]  = a;
    core_wdata[i] = wd;
    core_wstrb[i] = ws;
    core_instr[i] = ins;
    core_valid[i] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!core_ready[i] && n < 200);
    if (!core_ready[i]) begin
      checks++;
      errors++;
      $display("FAIL ready_wait core %0d: got no ready required ready within 200 cycles", i);
    end
    @(posedge clk);
    #1;
    if (gap > 0) begin
      core_valid[i] = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pop the expected completion whenever a core sees ready.
  exp_t mon_e;
  always @(negedge clk) begin
    for (int i = 0; i < int'(N); i++) begin
      if (core_ready[i]) begin
        if (exp_q[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready core %0d: got ready required none", i);
        end else begin
          mon_e = exp_q[i].pop_front();
          check($sformatf("core%0d_err", i), 32'(core_err[i]), 32'(mon_e.err));
          if (mon_e.chk_data) check($sformatf("core%0d_rdata", i), core_rdata[i], mon_e.rdata);
          check($sformatf("core%0d_grant_id", i), 32'(grant_id), 32'(i));
          served_q.push_back(i);
        end
      end else if (core_err[i]) begin
        checks++;
        errors++;
        $display("FAIL stray_err core %0d: got err without ready required 0", i);
      end
    end
  end

  // Downstream memory responder with per-request latency from the request queue.
  req_t        cur;
  int unsigned rc;
  int unsigned w;
  int          issue_n;
  logic        busy;
  logic        acked;
  logic [31:0] exp_ma;
  logic [31:0] rd;
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    busy      = 1'b0;
    acked     = 1'b0;
    issue_n   = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy      = 1'b0;
        mem_ready = 1'b0;
      end else begin
        if (busy && !mem_valid) begin
          if (!acked) check("timeout_len", 32'(issue_n), TMO);
          busy      = 1'b0;
          mem_ready = 1'b0;
        end
        if (!busy && mem_valid) begin
          rc      = mem_addr / REGION;
          busy    = 1'b1;
          acked   = 1'b0;
          issue_n = 0;
          if (rc < N && req_q[rc].size() > 0) begin
            cur    = req_q[rc].pop_front();
            exp_ma = 32'(rc * REGION) + cur.addr;
          end else begin
            checks++;
            errors++;
            $display("FAIL unexpected_mem: got access at %h required no access", mem_addr);
            cur    = '{addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb, instr: mem_instr,
                       lat: 0};
            exp_ma = mem_addr;
          end
        end
        if (busy && mem_valid) begin
          issue_n++;
          check("mem_addr", mem_addr, exp_ma);
          check("mem_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
          check("mem_instr", 32'(mem_instr), 32'(cur.instr));
          if (cur.wstrb != 4'd0) check("mem_wdata", mem_wdata, cur.wdata);
          if (issue_n > int'(TMO)) begin
            checks++;
            errors++;
            $display("FAIL timeout_late: got %0d issue cycles required at most %0d", issue_n, TMO);
          end
          if (!acked && issue_n - 1 == cur.lat) begin
            w         = mem_addr >> 2;
            rd        = mem.exists(w) ? mem[w] : init_word(w);
            mem_rdata = rd;
            mem[w]    = merge(rd, mem_wdata, mem_wstrb);
            mem_ready = 1'b1;
            acked     = 1'b1;
          end else begin
            mem_ready = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1);
  end

  initial begin
    int n;
    req_t r;
    reset      = 1'b1;
    core_valid = '0;
    core_instr = '0;
    core_addr  = '0;
    core_wdata = '0;
    core_wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_valid", 32'(mem_valid), 0);
    check("rst_core_ready", 32'(core_ready), 0);
    check("rst_core_err", 32'(core_err), 0);
    check("rst_rdata0", core_rdata[0], 0);
    check("rst_rdata1", core_rdata[1], 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Directed cases: plain read, edge-of-window write, out-of-window accesses, timeouts.
    do_txn(0, 32'h8, 32'h0, 4'h0, 1'b0, 2, 1);
    do_txn(1, 32'h3FC, 32'h55, 4'b0001, 1'b0, 1, 1);
    do_txn(1, 32'h3FC, 32'h0, 4'h0, 1'b0, 0, 1);
    do_txn(0, 32'h400, 32'h0, 4'h0, 1'b0, 0, 1);
    do_txn(1, 32'h800, 32'h1234, 4'hF, 1'b0, 0, 1);
    do_txn(0, 32'h20, 32'h0, 4'h0, 1'b0, 10, 1);
    do_txn(0, 32'h20, 32'h0, 4'h0, 1'b1, 0, 1);
    do_txn(0, 32'h24, 32'h0, 4'h0, 1'b0, TMO - 1, 1);
    do_txn(1, 32'h24, 32'hFFFFFFFF, 4'hF, 1'b0, TMO, 1);
    do_txn(1, 32'h24, 32'h0, 4'h0, 1'b0, 0, 1);

    // Both cores continuously requesting must be served alternately.
    served_q.delete();
    fork
      for (int k = 0; k < 4; k++) do_txn(0, 32'(k * 4), 32'h0, 4'h0, 1'b0, 0, (k == 3) ? 1 : 0);
      for (int k = 0; k < 4; k++) do_txn(1, 32'h10, 32'h0, 4'h0, 1'b0, 0, (k == 3) ? 1 : 0);
    join
    check("alt_count", 32'(served_q.size()), 8);
    for (int k = 1; k < served_q.size(); k++) begin
      checks++;
      if (served_q[k] == served_q[k-1]) begin
        errors++;
        $display("FAIL alternation at %0d: got core %0d twice required alternate", k, served_q[k]);
      end
    end

    // Reset during ISSUE: last grant was core 0, so only reset makes core 0 win again.
    do_txn(0, 32'h40, 32'h0, 4'h0, 1'b0, 0, 1);
    r = '{addr: 32'h44, wdata: 32'h0, wstrb: 4'h0, instr: 1'b0, lat: 50};
    req_q[0].push_back(r);
    core_addr[0]  = 32'h44;
    core_wstrb[0] = 4'h0;
    core_valid[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_valid && n < 20);
    check("rst_test_issue", 32'(mem_valid), 1);
    #2 reset = 1'b1;
    #1 check("async_mem_valid_drop", 32'(mem_valid), 0);
    core_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_ready", 32'(core_ready), 0);
    req_q[0].delete();
    @(posedge clk);
    #1 reset = 1'b0;
    served_q.delete();
    fork
      do_txn(0, 32'h48, 32'h0, 4'h0, 1'b0, 0, 1);
      do_txn(1, 32'h48, 32'h0, 4'h0, 1'b0, 0, 1);
    join
    check("first_after_reset", (served_q.size() > 0) ? 32'(served_q[0]) : 32'hFFFFFFFF, 0);

    // Randomized traffic from both cores.
    fork
      for (int k = 0; k < 30; k++)
        do_txn(0, ($urandom_range(0, 9) == 0) ? REGION + ($urandom_range(0, 255) << 2)
                                              : ($urandom_range(0, 15) << 2),
               $urandom, $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, TMO + 1)),
               (k == 29) ? 1 : int'($urandom_range(0, 2)));
      for (int k = 0; k < 30; k++)
        do_txn(1, ($urandom_range(0, 9) == 0) ? REGION + ($urandom_range(0, 255) << 2)
                                              : ($urandom_range(0, 15) << 2),
               $urandom, $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, TMO + 1)),
               (k == 29) ? 1 : int'($urandom_range(0, 2)));
    join

    repeat (5) @(posedge clk);
    check("exp_q0_drained", 32'(exp_q[0].size()), 0);
    check("exp_q1_drained", 32'(exp_q[1].size()), 0);
    check("req_q0_drained", 32'(req_q[0].size()), 0);
    check("req_q1_drained", 32'(req_q[1].size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
